// File: rtl/seq_stage_ctrl.sv
// Y86-64 SEQ stage sequencer: one stage enable per cycle, data-memory handshake, status code.
// Optional cycle/retired counters are built only when SEQ_PERF_CNT_EN is defined.
module seq_stage_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ack,
  input  logic             dmem_error,
  output logic             mem_req,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Wait counter value seen in the last allowed MEMORY cycle (counter starts at 0).
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] stat_q, stat_d;
  logic [3:0] icode_q;
  logic [7:0] wait_q, wait_d;
  logic       is_mem;

  assign is_mem = icode_q inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};

  // NOTE: sequential state uses non-blocking assignments only; combinational logic uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= 4'd0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      wait_q  <= wait_d;
      if (state_q == S_FETCH) icode_q <= icode;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else if (!instr_valid) begin
          state_d = S_HALTED;
          stat_d  = STAT_INS;
        end else if (icode == 4'd0) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_MEMORY;
        wait_d  = 8'd0;
      end
      S_MEMORY: begin
        if (!is_mem) begin
          state_d = S_WRITEBACK;
        end else if (mem_ack) begin
          // An ack in the last allowed cycle still beats the timeout.
          state_d = dmem_error ? S_HALTED : S_WRITEBACK;
          if (dmem_error) stat_d = STAT_ADR;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD:     state_d = S_FETCH;
      S_HALTED:    state_d = S_HALTED;
      default:     state_d = S_IDLE;
    endcase
  end

  assign f_en    = (state_q == S_FETCH);
  assign d_en    = (state_q == S_DECODE);
  assign e_en    = (state_q == S_EXECUTE);
  assign m_en    = (state_q == S_MEMORY);
  assign w_en    = (state_q == S_WRITEBACK);
  assign pc_en   = (state_q == S_PCUPD);
  assign mem_req = m_en && is_mem;
  assign halted  = (state_q == S_HALTED);
  assign busy    = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign stat    = stat_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      if (busy && (cyc_q != '1)) cyc_q <= cyc_q + 1'b1;
      if (pc_en && (instr_q != '1)) instr_q <= instr_q + 1'b1;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`else
  assign cyc_cnt   = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed scenarios plus a randomized instruction stream
// compared against a stage-token reference model.
module tb_seq_stage_ctrl;
  localparam int CNT_W       = 6;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef enum int {T_F = 0, T_D = 1, T_E = 2, T_M = 3, T_W = 4, T_P = 5} tok_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       icode = 4'd0;
  logic             instr_valid = 1'b0;
  logic             imem_error = 1'b0;
  logic             mem_ack = 1'b0;
  logic             dmem_error = 1'b0;
  logic             mem_req, f_en, d_en, e_en, m_en, w_en, pc_en, halted, busy;
  logic [2:0]       stat;
  logic [CNT_W-1:0] cyc_cnt, instr_cnt;
  logic [5:0]       en_vec;

  int total = 0;
  int bad   = 0;
  int exp_cyc = 0;
  int exp_instr = 0;

  seq_stage_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error), .mem_req(mem_req),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en), .pc_en(pc_en),
    .stat(stat), .halted(halted), .busy(busy), .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;
  assign en_vec = {f_en, d_en, e_en, m_en, w_en, pc_en};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_exp(input int v);
`ifdef SEQ_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cyc"}, 32'(cyc_cnt), 32'(cnt_exp(exp_cyc)));
    check({tag, "_instr"}, 32'(instr_cnt), 32'(cnt_exp(exp_instr)));
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0;
    tick();
    check("rst_en", 32'(en_vec), 32'd0);
    check("rst_mreq", 32'(mem_req), 32'd0);
    check("rst_stat", 32'(stat), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    exp_cyc = 0;
    exp_instr = 0;
    check_counters("rst");
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives one instruction from FETCH onward; ack_at is the MEMORY cycle (1-based) carrying mem_ack, 0 = never.
  task automatic do_instr(input logic [3:0] ic, input bit valid, input bit ierr,
                          input int ack_at, input bit derr);
    tok_t q[$];
    int   n_m;
    int   m_idx = 0;
    int   halt_stat = 0;
    bit   mem_ins = ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    q.push_back(T_F);
    if (ierr) halt_stat = 3;
    else if (!valid) halt_stat = 4;
    else if (ic == 4'd0) halt_stat = 2;
    else begin
      q.push_back(T_D);
      q.push_back(T_E);
      if (mem_ins) begin
        n_m = (ack_at >= 1 && ack_at <= MEM_TIMEOUT) ? ack_at : MEM_TIMEOUT;
        repeat (n_m) q.push_back(T_M);
        if (n_m != ack_at || derr) halt_stat = 3;
        else begin
          q.push_back(T_W);
          q.push_back(T_P);
        end
      end else begin
        q.push_back(T_M);
        q.push_back(T_W);
        q.push_back(T_P);
      end
    end
    foreach (q[i]) begin
      check("stage_en", 32'(en_vec), 32'(6'b100000 >> int'(q[i])));
      check("stage_mreq", 32'(mem_req), 32'(q[i] == T_M && mem_ins));
      check("stage_busy", 32'(busy), 32'd1);
      check("stage_stat", 32'(stat), 32'd1);
      start       = 1'($urandom_range(0, 1));
      icode       = 4'($urandom_range(0, 15));
      instr_valid = 1'($urandom_range(0, 1));
      imem_error  = 1'($urandom_range(0, 1));
      mem_ack     = 1'($urandom_range(0, 1));
      dmem_error  = 1'($urandom_range(0, 1));
      if (q[i] == T_F) begin
        icode = ic; instr_valid = valid; imem_error = ierr;
      end
      if (q[i] == T_M && mem_ins) begin
        m_idx++;
        mem_ack = (m_idx == ack_at);
        if (mem_ack) dmem_error = derr;
      end
      tick();
      exp_cyc = sat_inc(exp_cyc);
      if (q[i] == T_P) exp_instr = sat_inc(exp_instr);
      check_counters("stage");
    end
    start = 1'b0;
    mem_ack = 1'b0;
    if (halt_stat != 0) begin
      check("halt_stat", 32'(stat), 32'(halt_stat));
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_busy", 32'(busy), 32'd0);
      check("halt_en", 32'(en_vec), 32'd0);
    end
  endtask

  // HALTED must hold through start pulses and input noise.
  task automatic stay_halted(input int exp_stat);
    repeat (4) begin
      start   = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      icode   = 4'($urandom_range(0, 15));
      tick();
      check("hold_halted", 32'(halted), 32'd1);
      check("hold_stat", 32'(stat), 32'(exp_stat));
      check("hold_en", 32'(en_vec | 6'(mem_req)), 32'd0);
      check_counters("hold");
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset and IDLE ignoring time.
    do_reset();
    repeat (3) begin
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_en", 32'(en_vec), 32'd0);
    end
    check_counters("idle");

    // Straight-line run: three OPq-style instructions then halt.
    do_start();
    repeat (3) do_instr(4'd2, 1'b1, 1'b0, 0, 1'b0);
    do_instr(4'd0, 1'b1, 1'b0, 0, 1'b0);
    check("straight_cyc", 32'(cyc_cnt), 32'(cnt_exp(19)));
    check("straight_instr", 32'(instr_cnt), 32'(cnt_exp(3)));
    stay_halted(2);

    // Memory wait of 3 cycles, then timeout.
    do_reset();
    do_start();
    do_instr(4'd5, 1'b1, 1'b0, 3, 1'b0);
    check("memwait_next_fetch", 32'(f_en), 32'd1);
    check("memwait_cyc", 32'(cyc_cnt), 32'(cnt_exp(8)));
    do_instr(4'd4, 1'b1, 1'b0, 0, 1'b0);
    check("timeout_instr", 32'(instr_cnt), 32'(cnt_exp(1)));
    stay_halted(3);

    // Fetch faults: ADR beats INS; INS alone.
    do_reset();
    do_start();
    do_instr(4'd2, 1'b0, 1'b1, 0, 1'b0);
    stay_halted(3);
    do_reset();
    do_start();
    do_instr(4'd6, 1'b0, 1'b0, 0, 1'b0);
    stay_halted(4);

    // Data fault on first MEMORY cycle.
    do_reset();
    do_start();
    do_instr(4'd2, 1'b1, 1'b0, 0, 1'b0);
    do_instr(4'd9, 1'b1, 1'b0, 1, 1'b1);
    check("dfault_instr", 32'(instr_cnt), 32'(cnt_exp(1)));
    stay_halted(3);

    // Randomized stream with boundary acks (first and last allowed cycle), then halt.
    do_reset();
    do_start();
    do_instr(4'd8, 1'b1, 1'b0, MEM_TIMEOUT, 1'b0);
    do_instr(4'd10, 1'b1, 1'b0, 1, 1'b0);
    for (int n = 0; n < 40; n++)
      do_instr(4'($urandom_range(1, 15)), 1'b1, 1'b0, $urandom_range(1, MEM_TIMEOUT), 1'b0);
    do_instr(4'd0, 1'b1, 1'b0, 0, 1'b0);
    stay_halted(2);

    // Reset in the middle of a memory wait.
    do_reset();
    do_start();
    icode = 4'd8; instr_valid = 1'b1; imem_error = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    tick();
    check("mid_mreq1", 32'(mem_req), 32'd1);
    tick();
    check("mid_mreq2", 32'(mem_req), 32'd1);
    check("mid_cyc", 32'(cyc_cnt), 32'(cnt_exp(4)));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mreq", 32'(mem_req), 32'd0);
    check("mid_rst_en", 32'(en_vec), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stat", 32'(stat), 32'd1);
    check("mid_rst_cyc", 32'(cyc_cnt), 32'd0);
    check("mid_rst_instr", 32'(instr_cnt), 32'd0);
    tick();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog expired");
  end

endmodule
